// File: rtl/dds_pkg.sv
// Shared constants for the piecewise-linear DDS: bus widths, segment
// breakpoints and per-segment slopes of the quarter-wave line function.
package dds_pkg;
  localparam int PHASE_W = 8;
  localparam int DATA_W  = 8;

  localparam logic [6:0] Y0 = 7'd0;
  localparam logic [6:0] Y1 = 7'd49;
  localparam logic [6:0] Y2 = 7'd90;
  localparam logic [6:0] Y3 = 7'd117;
  localparam logic [6:0] Y4 = 7'd127;

  // Slopes are Y[k+1]-Y[k]; kept explicit so the multiplier stays 6x4 bits.
  localparam logic [5:0] D0 = 6'd49;
  localparam logic [5:0] D1 = 6'd41;
  localparam logic [5:0] D2 = 6'd27;
  localparam logic [5:0] D3 = 6'd10;
endpackage

// File: rtl/dds_line_interp.sv
// Combinational quarter-wave line function: 6-bit position in, 7-bit magnitude
// out. The x=64 end point is outside this range and is handled by the caller.
module dds_line_interp
  import dds_pkg::*;
(
  input  logic [5:0] x,
  output logic [6:0] mag
);

  logic [6:0] base;
  logic [5:0] slope;

  always_comb begin
    base  = Y0;
    slope = D0;
    case (x[5:4])
      2'd0: begin base = Y0; slope = D0; end
      2'd1: begin base = Y1; slope = D1; end
      2'd2: begin base = Y2; slope = D2; end
      2'd3: begin base = Y3; slope = D3; end
      default: begin base = Y0; slope = D0; end
    endcase
  end

  // Largest product is 49*15=735; after the shift the sum never exceeds 126.
  assign mag = base + 7'(({4'b0, slope} * {6'b0, x[3:0]}) >> 4);

endmodule

// File: rtl/dds_line.sv
// Direct digital synthesiser: phase accumulator plus interpolated sine output
// registered one cycle after the phase, with a one-cycle pulse on each wrap.
module dds_line #(
  parameter int PHASE_W      = dds_pkg::PHASE_W,
  parameter int DATA_W       = dds_pkg::DATA_W,
  parameter int DEFAULT_STEP = 1
) (
  input  logic                     CLK,
  input  logic                     RESET,
  input  logic                     SET,
  input  logic [PHASE_W-1:0]       step_in,
  output logic signed [DATA_W-1:0] value,
  output logic                     zero_address
);

  logic [PHASE_W-1:0] step_reg;
  logic [PHASE_W-1:0] phase;
  logic [PHASE_W:0]   sum;
  logic [1:0]         quad;
  logic [5:0]         q;
  logic [5:0]         x;
  logic [6:0]         mag;
  logic [6:0]         mag_sel;
  logic [DATA_W-1:0]  sample;

  assign sum  = {1'b0, phase} + {1'b0, step_reg};
  assign quad = phase[PHASE_W-1:PHASE_W-2];
  assign q    = phase[5:0];

  // Odd quadrants run the line backwards; 64-q in 6 bits is just -q.
  assign x = quad[0] ? (6'd0 - q) : q;

  dds_line_interp u_interp (
    .x   (x),
    .mag (mag)
  );

  assign mag_sel = (quad[0] && (q == 6'd0)) ? dds_pkg::Y4 : mag;
  assign sample  = quad[1] ? (DATA_W'(0) - DATA_W'(mag_sel)) : DATA_W'(mag_sel);

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      step_reg     <= PHASE_W'(DEFAULT_STEP);
      phase        <= '0;
      value        <= '0;
      zero_address <= 1'b0;
    end else begin
      value <= sample;
      if (SET) begin
        step_reg     <= step_in;
        phase        <= '0;
        zero_address <= 1'b0;
      end else begin
        phase        <= sum[PHASE_W-1:0];
        zero_address <= sum[PHASE_W];
      end
    end
  end

endmodule

// File: tb/tb_dds_line.sv
// Randomised scoreboard bench for dds_line: the stimulus side predicts each
// cycle's outputs from an arithmetic sine model, a monitor compares them.
module tb_dds_line;

  logic              CLK;
  logic              RESET;
  logic              SET;
  logic [7:0]        step_in;
  logic signed [7:0] value;
  logic              zero_address;

  dds_line #(.PHASE_W(8), .DATA_W(8), .DEFAULT_STEP(1)) dut (
    .CLK          (CLK),
    .RESET        (RESET),
    .SET          (SET),
    .step_in      (step_in),
    .value        (value),
    .zero_address (zero_address)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  typedef struct {
    logic signed [7:0] v;
    logic              z;
    int                ph;
    int                stp;
    int                gen;
  } exp_t;

  exp_t exp_q[$];

  int n_checks = 0;
  int n_fail   = 0;

  int m_ph  = 0;
  int m_stp = 1;
  int gen   = 0;

  logic signed [7:0] seen_v [256];
  bit                seen   [256];

  function automatic int line_fn(input int x);
    int yb[5];
    int k;
    int f;
    yb = '{0, 49, 90, 117, 127};
    if (x == 64) return 127;
    k = x / 16;
    f = x % 16;
    return yb[k] + ((yb[k+1] - yb[k]) * f) / 16;
  endfunction

  function automatic int sine_fn(input int p);
    int qd;
    int qq;
    qd = p / 64;
    qq = p % 64;
    case (qd)
      0: return  line_fn(qq);
      1: return  line_fn(64 - qq);
      2: return -line_fn(qq);
      default: return -line_fn(64 - qq);
    endcase
  endfunction

  task automatic step_cyc(input bit set, input int sin);
    exp_t e;
    @(negedge CLK);
    RESET   = 1'b1;
    SET     = set;
    step_in = 8'(sin);
    e.v  = 8'(sine_fn(m_ph));
    e.ph = m_ph;
    if (set) begin
      e.z   = 1'b0;
      m_stp = sin;
      m_ph  = 0;
      gen++;
    end else begin
      e.z  = (m_ph + m_stp) >= 256;
      m_ph = (m_ph + m_stp) % 256;
    end
    e.stp = m_stp;
    e.gen = gen;
    exp_q.push_back(e);
  endtask

  task automatic rst_cyc();
    exp_t e;
    @(negedge CLK);
    RESET = 1'b0;
    SET   = 1'b0;
    m_ph  = 0;
    m_stp = 1;
    gen++;
    e.v = 8'sd0; e.z = 1'b0; e.ph = -1; e.stp = 1; e.gen = gen;
    exp_q.push_back(e);
    #1;
    n_checks++;
    if (value !== 8'sd0) begin
      n_fail++;
      $display("FAIL reset_value: got %0d expected 0", value);
    end
    n_checks++;
    if (zero_address !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_zero: got %b expected 0", zero_address);
    end
  endtask

  // Monitor: one expected entry per clock edge once stimulus is running.
  initial begin
    exp_t e;
    int cyc = 0;
    int last_pulse = -1;
    int last_gen = -1;
    int gap;
    logic signed [7:0] bp;
    bit has_bp;
    forever begin
      @(posedge CLK);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        cyc++;
        n_checks++;
        if (value !== e.v) begin
          n_fail++;
          $display("FAIL value@phase%0d: got %0d expected %0d", e.ph, value, e.v);
        end
        n_checks++;
        if (zero_address !== e.z) begin
          n_fail++;
          $display("FAIL zero_address@phase%0d: got %b expected %b", e.ph, zero_address, e.z);
        end
        if (e.ph >= 0) begin
          seen[e.ph]   = 1'b1;
          seen_v[e.ph] = value;
        end
        has_bp = 1'b1;
        case (e.ph)
          8:   bp = 8'sd24;
          16:  bp = 8'sd49;
          32:  bp = 8'sd90;
          48:  bp = 8'sd117;
          64:  bp = 8'sd127;
          128: bp = 8'sd0;
          192: bp = -8'sd127;
          default: begin bp = 8'sd0; has_bp = 1'b0; end
        endcase
        if (has_bp) begin
          n_checks++;
          if (value !== bp) begin
            n_fail++;
            $display("FAIL breakpoint@phase%0d: got %0d expected %0d", e.ph, value, bp);
          end
        end
        if (e.gen != last_gen) begin
          last_gen   = e.gen;
          last_pulse = -1;
        end
        if (zero_address === 1'b1) begin
          if (last_pulse >= 0 && e.stp > 0) begin
            gap = cyc - last_pulse;
            n_checks++;
            if (gap < 256 / e.stp || gap > (256 + e.stp - 1) / e.stp) begin
              n_fail++;
              $display("FAIL wrap_gap step%0d: got %0d expected %0d..%0d",
                       e.stp, gap, 256 / e.stp, (256 + e.stp - 1) / e.stp);
            end
          end
          last_pulse = cyc;
        end
      end
    end
  end

  initial begin
    int s_list[3];
    bit found;
    int waited;
    s_list = '{3, 4, 5};
    RESET = 1'b0;
    SET = 1'b0;
    step_in = 8'd0;
    repeat (3) rst_cyc();

    repeat (600) step_cyc(1'b0, 0);

    step_cyc(1'b1, 2);
    repeat (300) step_cyc(1'b0, 0);

    foreach (s_list[i]) begin
      step_cyc(1'b1, s_list[i]);
      repeat (1799) step_cyc(1'b0, 0);
    end

    // SET landing on the cycle the accumulator would wrap.
    found = 1'b0;
    for (int i = 0; i < 300 && !found; i++) begin
      if (m_ph + m_stp >= 256) begin
        step_cyc(1'b1, 4);
        found = 1'b1;
      end else begin
        step_cyc(1'b0, 0);
      end
    end
    n_checks++;
    if (!found) begin
      n_fail++;
      $display("FAIL set_on_wrap: got no wrap cycle expected one within 300");
    end
    repeat (100) step_cyc(1'b0, 0);

    step_cyc(1'b1, 0);
    repeat (50) step_cyc(1'b0, 0);

    step_cyc(1'b1, 255);
    repeat (600) step_cyc(1'b0, 0);

    repeat (800) begin
      if ($urandom % 40 == 0) step_cyc(1'b1, int'($urandom_range(0, 255)));
      else step_cyc(1'b0, 0);
    end

    // Full step-1 circle, then asynchronous reset around phase 100.
    step_cyc(1'b1, 1);
    repeat (300) step_cyc(1'b0, 0);
    for (int i = 0; i < 300 && m_ph != 100; i++) step_cyc(1'b0, 0);
    repeat (2) rst_cyc();
    repeat (300) step_cyc(1'b0, 0);

    waited = 0;
    while (exp_q.size() > 0 && waited < 10) begin
      @(negedge CLK);
      waited++;
    end
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end

    for (int p = 0; p < 128; p++) begin
      if (seen[p] && seen[p+128]) begin
        n_checks++;
        if (int'(seen_v[p]) + int'(seen_v[p+128]) != 0) begin
          n_fail++;
          $display("FAIL symmetry@%0d: got %0d+%0d expected sum 0", p, seen_v[p], seen_v[p+128]);
        end
      end
    end
    for (int p = 0; p < 63; p++) begin
      if (seen[p] && seen[p+1]) begin
        n_checks++;
        if (seen_v[p+1] < seen_v[p]) begin
          n_fail++;
          $display("FAIL q0_monotonic@%0d: got %0d then %0d expected nondecreasing", p, seen_v[p], seen_v[p+1]);
        end
      end
      if (seen[p+64] && seen[p+65]) begin
        n_checks++;
        if (seen_v[p+65] > seen_v[p+64]) begin
          n_fail++;
          $display("FAIL q1_monotonic@%0d: got %0d then %0d expected nonincreasing", p + 64, seen_v[p+64], seen_v[p+65]);
        end
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
